aes128_round_seq: RTL
=====================

AES128_ROUND_SEQ -- requirements
Module: aes128_round_seq

Interface
REQ-001 Parameter ROUND_LAT, default 4: clock cycles from round issue to a valid round result on the shared round datapath (range 1..15).
REQ-002 CLK  input  1  sole clock, rising edge.
REQ-003 RST  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request an encryption; accepted only in IDLE.
REQ-005 key_in  input  128  cipher key, sampled on start acceptance.
REQ-006 data_in  input  128  plaintext, sampled on start acceptance.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 rd_issue  output  1  one-cycle strobe launching one round on the shared datapath.
REQ-009 rd_data  output  128  round input state to the datapath.
REQ-010 rd_key  output  128  round key for the issued round.
REQ-011 rd_last  output  1  high with rd_issue for round 10 only (datapath bypasses MixColumns).
REQ-012 rd_result  input  128  datapath output, valid ROUND_LAT cycles after rd_issue.
REQ-013 out_valid  output  1  ciphertext available.
REQ-014 out_ready  input  1  consumer accepts ciphertext when high with out_valid.
REQ-015 data_out  output  128  ciphertext, stable while out_valid is high.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, WAIT, HOLD; encoding is local to the module.
REQ-017 IDLE with start=1: state_reg <= data_in ^ key_in (round-0 AddRoundKey), key_reg <= key_in, round_cnt <= 1, go to ISSUE.
REQ-018 ISSUE (one cycle): rd_issue=1, rd_data=state_reg, rd_key=next round key derived from key_reg and rcon[round_cnt], rd_last=(round_cnt==10); key_reg <= that key; wait_cnt <= ROUND_LAT-1; go to WAIT.
REQ-019 WAIT: wait_cnt decrements each cycle; when wait_cnt==0, state_reg <= rd_result, then go to ISSUE with round_cnt+1 if round_cnt<10, else go to HOLD.
REQ-020 rcon sequence SHALL be 01,02,04,08,10,20,40,80,1B,36 for rounds 1..10.
REQ-021 HOLD: out_valid=1, data_out=state_reg; on out_ready=1 go to IDLE; out_ready outside HOLD SHALL be ignored.
REQ-022 Start accepted at edge 0 SHALL issue round r at cycle 1+(r-1)(ROUND_LAT+1), and SHALL raise out_valid at cycle 10(ROUND_LAT+1)+1 (51 for the default).
REQ-023 start SHALL be ignored while busy; inputs changing after acceptance SHALL not affect the result.
REQ-024 start and out_ready both high in HOLD: SHALL return to IDLE only; the new start is accepted no earlier than the next cycle.
REQ-025 rd_issue SHALL never be asserted in two consecutive cycles, nor outside ISSUE.
REQ-026 rd_data, rd_key and rd_last SHALL be zero whenever rd_issue is low.
REQ-027 round_cnt SHALL be 4 bits and never exceed 10.

Reset
REQ-028 RST=1 SHALL immediately force IDLE, busy=0, rd_issue=0, rd_last=0, out_valid=0, and data_out, rd_data, rd_key, state_reg, key_reg, round_cnt and wait_cnt to 0.
REQ-029 RST asserted mid-operation SHALL abort the encryption with no out_valid; the first start after release SHALL run from round 1.

Structure
REQ-030 Rcon table, round count (10) and state-width constants SHALL reside in a shared package aes128_pkg.
REQ-031 The one-step key expansion (RotWord, SubWord, rcon XOR, word chaining) SHALL be a combinational sub-module aes128_key_step; the FSM, counters and registers stay in aes128_round_seq.

Verification
REQ-032 FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff, out_ready=1, with the bench round model -> data_out 69c4e0d86a7b0430d8cdb78070b4c55a, out_valid at cycle 51.
REQ-033 Same vector, out_ready held low for 20 cycles -> out_valid and data_out stay stable for 20 cycles, then IDLE one cycle after out_ready rises.
REQ-034 Pulse start at cycles 5 and 30 during an operation -> ignored; exactly 10 rd_issue pulses; rd_last on the 10th pulse only.
REQ-035 Assert RST at cycle 27 -> busy=0 and all outputs zero at once; restart with FIPS-197 C.1 -> correct ciphertext.
REQ-036 ROUND_LAT=1 and ROUND_LAT=15 builds with FIPS-197 C.1 -> correct ciphertext, out_valid at cycles 21 and 161.
REQ-037 Back-to-back: start high in the out_ready-accept cycle -> second start accepted the following cycle; both ciphertexts correct.

Source files
------------

// File: rtl/aes128_pkg.sv
// Shared constants for the AES-128 round sequencer.
//   BLOCK_W    : width of a cipher block / round key
//   STATE_W    : width of the sequencer state encoding
//   CNT_W      : width of the round and latency counters
//   NUM_ROUNDS : AES-128 round count
//   rcon()     : round constant for rounds 1..10 (0 otherwise)
package aes128_pkg;

  localparam int BLOCK_W = 128;
  localparam int STATE_W = 2;
  localparam int CNT_W   = 4;

  localparam logic [CNT_W-1:0] NUM_ROUNDS = 4'd10;

  function automatic logic [7:0] rcon(input logic [CNT_W-1:0] rnd);
    logic [7:0] rc;
    case (rnd)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/aes128_key_step.sv
// One step of the AES-128 key schedule (purely combinational).
//   key_i  : current round key (word 0 in bits 127:96)
//   rcon_i : round constant for the round being produced
//   key_o  : next round key
module aes128_key_step
  import aes128_pkg::*;
(
  input  logic [BLOCK_W-1:0] key_i,
  input  logic [7:0]         rcon_i,
  output logic [BLOCK_W-1:0] key_o
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // S-box computed as GF(2^8) inverse (x^254, so 0 maps to 0) followed by
  // the affine transform; avoids carrying a 256-entry table.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = gf_mul(b, b);
    inv = sq;
    for (int k = 2; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub, t;
  logic [31:0] w4, w5, w6, w7;

  always_comb begin
    w0  = key_i[127:96];
    w1  = key_i[95:64];
    w2  = key_i[63:32];
    w3  = key_i[31:0];
    rot = {w3[23:0], w3[31:24]};
    sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
    t   = sub ^ {rcon_i, 24'h000000};
    w4  = w0 ^ t;
    w5  = w1 ^ w4;
    w6  = w2 ^ w5;
    w7  = w3 ^ w6;
    key_o = {w4, w5, w6, w7};
  end

endmodule

// File: rtl/aes128_round_seq.sv
// AES-128 encryption sequencer driving a shared, fixed-latency round datapath.
//   CLK, RST          : clock, async active-high reset
//   start             : request encryption (accepted in IDLE only)
//   key_in, data_in   : key / plaintext, sampled on acceptance
//   busy              : high outside IDLE
//   rd_issue          : one-cycle round launch strobe
//   rd_data, rd_key   : round input state and round key (zero when not issuing)
//   rd_last           : final round (no MixColumns), with rd_issue only
//   rd_result         : datapath output, valid ROUND_LAT cycles after rd_issue
//   out_valid, out_ready, data_out : ciphertext handshake
//
// state | meaning
// IDLE  | waiting for start
// ISSUE | launch one round, advance round key
// WAIT  | count down datapath latency, capture result
// HOLD  | ciphertext presented until out_ready
module aes128_round_seq
  import aes128_pkg::*;
#(
  parameter int ROUND_LAT = 4
)
(
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic [BLOCK_W-1:0] key_in,
  input  logic [BLOCK_W-1:0] data_in,
  output logic               busy,
  output logic               rd_issue,
  output logic [BLOCK_W-1:0] rd_data,
  output logic [BLOCK_W-1:0] rd_key,
  output logic               rd_last,
  input  logic [BLOCK_W-1:0] rd_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] data_out
);

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(ROUND_LAT - 1);

  state_e             st_q, st_d;
  logic [BLOCK_W-1:0] state_q, state_d;
  logic [BLOCK_W-1:0] key_q, key_d;
  logic [CNT_W-1:0]   round_q, round_d;
  logic [CNT_W-1:0]   wait_q, wait_d;
  logic [BLOCK_W-1:0] next_key;

  aes128_key_step u_key_step (
    .key_i  (key_q),
    .rcon_i (rcon(round_q)),
    .key_o  (next_key)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st_q    <= IDLE;
      state_q <= '0;
      key_q   <= '0;
      round_q <= '0;
      wait_q  <= '0;
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    st_d      = st_q;
    state_d   = state_q;
    key_d     = key_q;
    round_d   = round_q;
    wait_d    = wait_q;
    busy      = 1'b1;
    rd_issue  = 1'b0;
    rd_data   = '0;
    rd_key    = '0;
    rd_last   = 1'b0;
    out_valid = 1'b0;
    data_out  = '0;
    case (st_q)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = data_in ^ key_in;
          key_d   = key_in;
          round_d = CNT_W'(1);
          st_d    = ISSUE;
        end
      end
      ISSUE: begin
        rd_issue = 1'b1;
        rd_data  = state_q;
        rd_key   = next_key;
        rd_last  = (round_q == NUM_ROUNDS);
        key_d    = next_key;
        wait_d   = WAIT_INIT;
        st_d     = WAIT;
      end
      WAIT: begin
        if (wait_q == '0) begin
          state_d = rd_result;
          if (round_q < NUM_ROUNDS) begin
            round_d = round_q + CNT_W'(1);
            st_d    = ISSUE;
          end else begin
            st_d = HOLD;
          end
        end else begin
          wait_d = wait_q - CNT_W'(1);
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        data_out  = state_q;
        if (out_ready) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

endmodule
